// File: rtl/apb_wait_slave_mem_pkg.sv
// apb_slv_pkg: shared types and constants for the APB wait-state completer.
//   apb_slv_state_t : FSM state encoding (IDLE, ACCESS, DONE)
//   ADDR_LSB        : first word-index bit of the byte address
//   WAIT_CNT_W      : wait-state counter width
//   addr_in_range() : true when the word address lies inside the memory
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_slv_state_t;

    localparam int ADDR_LSB   = 2;
    localparam int WAIT_CNT_W = 4;
    localparam int ADDR_MAX_W = 64;

    // Callers zero-extend their address to ADDR_MAX_W so that one function
    // serves any ADDR_WIDTH.
    function automatic logic addr_in_range(input logic [ADDR_MAX_W-1:0] addr,
                                           input int unsigned num_words);
        return (addr >> ADDR_LSB) < ADDR_MAX_W'(num_words);
    endfunction

endpackage

// File: rtl/apb_wait_slave_mem_if.sv
// apb_wait_slave_mem_if: APB3 bus between requester (bridge) and completer.
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA : requester -> completer
//   PRDATA, PREADY, PSLVERR              : completer -> requester
interface apb_wait_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_slave_mem_regfile.sv
// apb_slv_regfile: word memory with one synchronous write port, one
// combinational read port, and asynchronous clear of every word.
//   clk_i, rst_i : clock, async active-high reset (clears all words)
//   we_i         : write enable
//   waddr_i      : write word index
//   wdata_i      : write data
//   raddr_i      : read word index
//   rdata_o      : read data (combinational)
module apb_slv_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [$clog2(NUM_WORDS)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [$clog2(NUM_WORDS)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/apb_wait_slave_mem.sv
// apb_wait_slave_mem: APB3 completer backed by a word-addressed memory,
// inserting WAIT_STATES wait cycles before PREADY on every transfer.
//   HCLK    : clock (bridge clock)
//   HRESET  : asynchronous active-high reset
//   bus     : APB slave modport (PSEL/PENABLE/PADDR/PWRITE/PWDATA in,
//             PRDATA/PREADY/PSLVERR out, all outputs registered)
// Build option: define APB_SLV_ERR_EN to answer out-of-range or misaligned
// accesses with PSLVERR; otherwise the index wraps and PADDR[1:0] is ignored.
//
// state  | meaning
// IDLE   | no transfer; waiting for a setup cycle
// ACCESS | transfer captured; counting wait states, PREADY on the last cycle
// DONE   | one cycle after completion; a new setup here starts back-to-back
module apb_wait_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WORDS   = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    apb_wait_slave_mem_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WS_INIT = WAIT_CNT_W'(WAIT_STATES);

    apb_slv_state_t        state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;

    logic                  setup;
    logic                  live_err;
    logic [IDX_W-1:0]      live_idx;
    logic                  ready_next;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;
    logic                  rd_write;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign setup    = bus.PSEL && !bus.PENABLE;
    assign live_idx = bus.PADDR[ADDR_LSB +: IDX_W];

`ifdef APB_SLV_ERR_EN
    assign live_err = !addr_in_range(ADDR_MAX_W'(bus.PADDR), NUM_WORDS)
                      || (bus.PADDR[1:0] != 2'b00);
`else
    assign live_err = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = WS_INIT;
                    idx_d   = live_idx;
                    write_d = bus.PWRITE;
                    wdata_d = bus.PWDATA;
                    err_d   = live_err;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (bus.PENABLE) begin
                    if (pready_q) begin
                        state_d = DONE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead: ready_next marks the
    // edge that opens the completion cycle, and the read port is steered to
    // the live address when that edge is also the capture edge (zero waits).
    always_comb begin
        ready_next = 1'b0;
        mem_we     = 1'b0;
        rd_idx     = idx_q;
        rd_err     = err_q;
        rd_write   = write_q;
        pready_d   = 1'b0;
        prdata_d   = '0;
        pslverr_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (setup && (WAIT_STATES == 0)) begin
                    ready_next = 1'b1;
                    rd_idx     = live_idx;
                    rd_err     = live_err;
                    rd_write   = bus.PWRITE;
                end
            end
            ACCESS: begin
                if (bus.PSEL && bus.PENABLE) begin
                    if (pready_q) begin
                        mem_we = write_q && !err_q;
                    end else if (cnt_q <= WAIT_CNT_W'(1)) begin
                        ready_next = 1'b1;
                    end
                end else if (bus.PSEL) begin
                    // PENABLE dropped mid-access: hold the response as is.
                    pready_d  = pready_q;
                    prdata_d  = prdata_q;
                    pslverr_d = pslverr_q;
                end
            end
            default: ;
        endcase
        if (ready_next) begin
            pready_d  = 1'b1;
            pslverr_d = rd_err;
            prdata_d  = (!rd_write && !rd_err) ? mem_rdata : '0;
        end
    end

    apb_slv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_regfile (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
endmodule
